udp_frame_tx_param: RTL and testbench

Parametrised UDP/IPv4/Ethernet frame transmitter. It sits between the accelerator's result/response logic and the Ethernet MAC TX AXI-Stream port. On a start pulse it latches the addressing and a MSG_BYTES payload, then computes the IPv4 header checksum internally. It streams a complete frame, zero-padded to the Ethernet minimum, over a DATA_BYTES-wide stream with byte keeps. Each frame carries an auto-incrementing IP identification field.

---
 rtl/udp_frame_tx_param.sv | 166 ++++++++++++++++
 tb/tb_udp_frame_tx_param.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_frame_tx_param.sv
// udp_frame_tx_param: latches addressing and payload on start, computes the IPv4
// header checksum, then streams a padded Ethernet/IPv4/UDP frame over AXI-Stream.
module udp_frame_tx_param #(
  parameter int         DATA_BYTES      = 1,
  parameter int         MSG_BYTES       = 2,
  parameter int         MIN_FRAME_BYTES = 60,
  parameter logic [7:0] TTL             = 8'h80
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [31:0]             ACCELERATOR_IP_ADDRESS,
  input  logic [47:0]             ACCELERATOR_MAC_ADDRESS,
  input  logic [15:0]             ACCELERATOR_UDP_PORT,
  input  logic [31:0]             RECIPIENT_IP_ADDRESS,
  input  logic [47:0]             RECIPIENT_MAC_ADDRESS,
  input  logic [15:0]             RECIPIENT_UDP_PORT,
  input  logic [8*MSG_BYTES-1:0]  RECIPIENT_MESSAGE,
  input  logic                    START_IP_TXN,
  output logic                    READY_FOR_SEND,
  output logic [8*DATA_BYTES-1:0] MAC_DATA_OUT,
  output logic [DATA_BYTES-1:0]   MAC_DATA_KEEP,
  output logic                    MAC_DATA_VALID,
  input  logic                    MAC_DATA_READY,
  output logic                    MAC_DATA_LAST,
  output logic                    MAC_DATA_TUSER,
  output logic [15:0]             PACKETS_SENT
);
  localparam int CONTENT = 42 + MSG_BYTES;
  localparam int FRAME = CONTENT > MIN_FRAME_BYTES ? CONTENT : MIN_FRAME_BYTES;
  localparam int BEATS = (FRAME + DATA_BYTES - 1) / DATA_BYTES;
  localparam int BW = $clog2(BEATS + 1);
  localparam int IW = $clog2(BEATS * DATA_BYTES);
  localparam int REM = FRAME % DATA_BYTES;
  localparam logic [DATA_BYTES-1:0] LAST_KEEP = {DATA_BYTES{1'b1}} >> ((DATA_BYTES - REM) % DATA_BYTES);
  localparam logic [15:0] IP_LEN = 16'(28 + MSG_BYTES);
  localparam logic [15:0] UDP_LEN = 16'(8 + MSG_BYTES);

  typedef enum logic [1:0] {IDLE, SUM, FOLD, SEND} state_t;

  state_t                 state_q, state_d;
  logic [47:0]            dmac_q, smac_q;
  logic [31:0]            sip_q, dip_q;
  logic [15:0]            sport_q, dport_q;
  logic [8*MSG_BYTES-1:0] msg_q;
  logic [31:0]            sum_q, sum_d;
  logic [15:0]            csum_q, csum_d, id_q, id_d, cnt_q, cnt_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [16:0]            fold1;
  logic [15:0]            fold2;
  logic [IW-1:0]          idx;
  logic [7:0]             frm [BEATS*DATA_BYTES];
  logic                   start, fire, last;

  assign start = state_q == IDLE && START_IP_TXN;
  assign fire = state_q == SEND && MAC_DATA_READY;
  assign last = beat_q == BW'(BEATS - 1);

  always_ff @(posedge ACLK or negedge ARESET)
    if (!ARESET) begin
      state_q <= IDLE;
      sum_q   <= '0;
      csum_q  <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      dmac_q  <= '0;
      smac_q  <= '0;
      sip_q   <= '0;
      dip_q   <= '0;
      sport_q <= '0;
      dport_q <= '0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      csum_q  <= csum_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      if (start) begin
        dmac_q  <= RECIPIENT_MAC_ADDRESS;
        smac_q  <= ACCELERATOR_MAC_ADDRESS;
        sip_q   <= ACCELERATOR_IP_ADDRESS;
        dip_q   <= RECIPIENT_IP_ADDRESS;
        sport_q <= ACCELERATOR_UDP_PORT;
        dport_q <= RECIPIENT_UDP_PORT;
        msg_q   <= RECIPIENT_MESSAGE;
      end
    end

  // Two folds suffice: the first leaves at most one carry, the second cannot overflow.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    csum_d  = csum_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    fold1   = {1'b0, sum_q[15:0]} + {1'b0, sum_q[31:16]};
    fold2   = fold1[15:0] + {15'b0, fold1[16]};
    unique case (state_q)
      IDLE: state_d = start ? SUM : IDLE;
      SUM: begin
        sum_d = 32'h4500 + IP_LEN + id_q + {TTL, 8'h11}
              + sip_q[31:16] + sip_q[15:0] + dip_q[31:16] + dip_q[15:0];
        state_d = FOLD;
      end
      FOLD: begin
        csum_d  = ~fold2;
        beat_d  = '0;
        state_d = SEND;
      end
      SEND: if (fire) begin
        state_d = last ? IDLE : SEND;
        beat_d  = last ? '0 : beat_q + BW'(1);
        id_d    = last ? id_q + 16'd1 : id_q;
        cnt_d   = last ? cnt_q + 16'd1 : cnt_q;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < BEATS * DATA_BYTES; i++) frm[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      frm[i]     = dmac_q[8*(5-i) +: 8];
      frm[6 + i] = smac_q[8*(5-i) +: 8];
    end
    frm[12] = 8'h08;
    frm[14] = 8'h45;
    frm[16] = IP_LEN[15:8];
    frm[17] = IP_LEN[7:0];
    frm[18] = id_q[15:8];
    frm[19] = id_q[7:0];
    frm[22] = TTL;
    frm[23] = 8'h11;
    frm[24] = csum_q[15:8];
    frm[25] = csum_q[7:0];
    for (int i = 0; i < 4; i++) begin
      frm[26 + i] = sip_q[8*(3-i) +: 8];
      frm[30 + i] = dip_q[8*(3-i) +: 8];
    end
    for (int i = 0; i < 2; i++) begin
      frm[34 + i] = sport_q[8*(1-i) +: 8];
      frm[36 + i] = dport_q[8*(1-i) +: 8];
    end
    frm[38] = UDP_LEN[15:8];
    frm[39] = UDP_LEN[7:0];
    for (int i = 0; i < MSG_BYTES; i++) frm[42 + i] = msg_q[8*(MSG_BYTES-1-i) +: 8];
  end

  assign READY_FOR_SEND = state_q == IDLE;
  assign MAC_DATA_VALID = state_q == SEND;
  assign MAC_DATA_LAST  = MAC_DATA_VALID && last;
  assign MAC_DATA_KEEP  = MAC_DATA_VALID ? (last ? LAST_KEEP : {DATA_BYTES{1'b1}}) : '0;
  assign MAC_DATA_TUSER = 1'b0;
  assign PACKETS_SENT   = cnt_q;

  always_comb begin
    MAC_DATA_OUT = '0;
    idx = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      idx = IW'(int'(beat_q) * DATA_BYTES + k);
      if (MAC_DATA_KEEP[k]) MAC_DATA_OUT[8*k +: 8] = frm[idx];
    end
  end
endmodule

// File: tb/tb_udp_frame_tx_param.sv
// tb_udp_frame_tx_param: scoreboard bench for a byte-serial and a 32-bit instance,
// with a byte-list frame model and independent ones-complement checksum.
module tb_udp_frame_tx_param;
  logic clk = 0;
  always #5 clk = ~clk;

  logic        ARESET = 0;
  logic [47:0] smac = 48'h54b00bedabba, dmac = 48'h32dabbadebd5;
  logic [31:0] sip = 32'h01020304, dip = 32'h0a0b0c0d;
  logic [15:0] sport = 16'h66ff, dport = 16'h99dd;
  logic [15:0] msg0 = 0;
  logic [159:0] msg1 = 0;
  logic st0 = 0, st1 = 0, rdy0 = 1, rdy1 = 1, rm0 = 0, rm1 = 0;

  logic        rfs0, v0, l0, u0, rfs1, v1, l1, u1;
  logic [7:0]  d0;
  logic [0:0]  k0;
  logic [31:0] d1;
  logic [3:0]  k1;
  logic [15:0] ps0, ps1;

  udp_frame_tx_param #(.DATA_BYTES(1), .MSG_BYTES(2), .MIN_FRAME_BYTES(60), .TTL(8'h80)) dut0 (
    .ACLK(clk), .ARESET(ARESET),
    .ACCELERATOR_IP_ADDRESS(sip), .ACCELERATOR_MAC_ADDRESS(smac), .ACCELERATOR_UDP_PORT(sport),
    .RECIPIENT_IP_ADDRESS(dip), .RECIPIENT_MAC_ADDRESS(dmac), .RECIPIENT_UDP_PORT(dport),
    .RECIPIENT_MESSAGE(msg0), .START_IP_TXN(st0), .READY_FOR_SEND(rfs0),
    .MAC_DATA_OUT(d0), .MAC_DATA_KEEP(k0), .MAC_DATA_VALID(v0), .MAC_DATA_READY(rdy0),
    .MAC_DATA_LAST(l0), .MAC_DATA_TUSER(u0), .PACKETS_SENT(ps0));

  udp_frame_tx_param #(.DATA_BYTES(4), .MSG_BYTES(20), .MIN_FRAME_BYTES(60), .TTL(8'h80)) dut1 (
    .ACLK(clk), .ARESET(ARESET),
    .ACCELERATOR_IP_ADDRESS(sip), .ACCELERATOR_MAC_ADDRESS(smac), .ACCELERATOR_UDP_PORT(sport),
    .RECIPIENT_IP_ADDRESS(dip), .RECIPIENT_MAC_ADDRESS(dmac), .RECIPIENT_UDP_PORT(dport),
    .RECIPIENT_MESSAGE(msg1), .START_IP_TXN(st1), .READY_FOR_SEND(rfs1),
    .MAC_DATA_OUT(d1), .MAC_DATA_KEEP(k1), .MAC_DATA_VALID(v1), .MAC_DATA_READY(rdy1),
    .MAC_DATA_LAST(l1), .MAC_DATA_TUSER(u1), .PACKETS_SENT(ps1));

  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} exp_t;
  exp_t q0[$], q1[$], e0, e1;
  logic [7:0] pl[$], fb[$], cap0[$], cap1[$];
  int vectors = 0, miscompares = 0, hs0 = 0, hs1 = 0;
  logic [15:0] id0_m = 0, id1_m = 0, exp_cs = 0;
  logic inf0 = 0, inf1 = 0, stl0 = 0, stl1 = 0, hl0 = 0, hl1 = 0;
  logic [7:0] hd0 = 0;
  logic [0:0] hk0 = 0;
  logic [31:0] hd1 = 0;
  logic [3:0] hk1 = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Frame as a plain byte list; checksum by summing words and folding until no carry.
  task automatic build(input int mb, input logic [15:0] id);
    logic [31:0] s;
    logic [15:0] iplen, udplen;
    iplen = 16'(28 + mb);
    udplen = 16'(8 + mb);
    s = 32'h4500 + iplen + id + 32'h8011 + sip[31:16] + sip[15:0] + dip[31:16] + dip[15:0];
    while (s >> 16 != 0) s = (s & 32'hffff) + (s >> 16);
    exp_cs = ~s[15:0];
    fb.delete();
    for (int i = 5; i >= 0; i--) fb.push_back(dmac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) fb.push_back(smac[8*i +: 8]);
    fb.push_back(8'h08); fb.push_back(8'h00); fb.push_back(8'h45); fb.push_back(8'h00);
    fb.push_back(iplen[15:8]); fb.push_back(iplen[7:0]);
    fb.push_back(id[15:8]); fb.push_back(id[7:0]);
    fb.push_back(8'h00); fb.push_back(8'h00); fb.push_back(8'h80); fb.push_back(8'h11);
    fb.push_back(exp_cs[15:8]); fb.push_back(exp_cs[7:0]);
    for (int i = 3; i >= 0; i--) fb.push_back(sip[8*i +: 8]);
    for (int i = 3; i >= 0; i--) fb.push_back(dip[8*i +: 8]);
    fb.push_back(sport[15:8]); fb.push_back(sport[7:0]);
    fb.push_back(dport[15:8]); fb.push_back(dport[7:0]);
    fb.push_back(udplen[15:8]); fb.push_back(udplen[7:0]);
    fb.push_back(8'h00); fb.push_back(8'h00);
    foreach (pl[j]) fb.push_back(pl[j]);
    while (fb.size() < 60) fb.push_back(8'h00);
  endtask

  task automatic push_exp(input int which, input int db);
    exp_t e;
    int nb;
    nb = (fb.size() + db - 1) / db;
    for (int b = 0; b < nb; b++) begin
      e = '0;
      for (int n = 0; n < db; n++)
        if (b * db + n < fb.size()) begin
          e.d[8*n +: 8] = fb[b*db+n];
          e.k[n] = 1'b1;
        end
      e.l = (b == nb - 1);
      if (which == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic start0;
    build(2, id0_m);
    push_exp(0, 1);
    id0_m++;
    msg0 = {pl[0], pl[1]};
    hs0 = 0;
    cap0.delete();
    st0 = 1;
    tick;
    st0 = 0;
  endtask

  task automatic start1;
    build(20, id1_m);
    push_exp(1, 4);
    id1_m++;
    for (int j = 0; j < 20; j++) msg1[8*(19-j) +: 8] = pl[j];
    hs1 = 0;
    st1 = 1;
    tick;
    st1 = 0;
  endtask

  task automatic wait_idle(input int which);
    int n;
    n = 0;
    while (which == 0 ? !(rfs0 && q0.size() == 0) : !(rfs1 && q1.size() == 0)) begin
      tick;
      n++;
      if (n > 3000) begin
        vectors++;
        miscompares++;
        $display("FAIL timeout dut%0d: frame did not complete", which);
        break;
      end
    end
  endtask

  task automatic wait_hs0(input int target);
    int n;
    n = 0;
    while (hs0 < target && n < 500) begin tick; n++; end
    check("reach_beat0", 64'(hs0), 64'(target));
  endtask

  task automatic rand_fields;
    smac = {16'($urandom), $urandom};
    dmac = {16'($urandom), $urandom};
    sip = $urandom;
    dip = $urandom;
    sport = 16'($urandom);
    dport = 16'($urandom);
  endtask

  always @(posedge clk) begin
    #1;
    if (rm0) rdy0 = $urandom_range(0, 3) != 0;
    if (rm1) rdy1 = $urandom_range(0, 3) != 0;
  end

  always @(negedge clk) begin
    if (!ARESET) begin
      inf0 = 0;
      stl0 = 0;
    end else begin
      if (inf0) check("valid0_held", 64'(v0), 64'd1);
      if (stl0) check("stable0", {d0, k0, l0}, {hd0, hk0, hl0});
      if (v0 && rdy0) begin
        if (q0.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL beat0: unexpected beat data %0h", d0);
        end else begin
          e0 = q0.pop_front();
          check("beat0", {d0, k0, l0}, {e0.d[7:0], e0.k[0], e0.l});
        end
        hs0++;
        cap0.push_back(d0);
        inf0 = !l0;
      end else inf0 = v0;
      stl0 = v0 && !rdy0;
      hd0 = d0;
      hk0 = k0;
      hl0 = l0;
    end
  end

  always @(negedge clk) begin
    if (!ARESET) begin
      inf1 = 0;
      stl1 = 0;
    end else begin
      if (inf1) check("valid1_held", 64'(v1), 64'd1);
      if (stl1) check("stable1", {d1, k1, l1}, {hd1, hk1, hl1});
      if (v1 && rdy1) begin
        if (q1.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL beat1: unexpected beat data %0h", d1);
        end else begin
          e1 = q1.pop_front();
          check("beat1", {d1, k1, l1}, {e1.d, e1.k, e1.l});
        end
        hs1++;
        for (int n = 0; n < 4; n++) if (k1[n]) cap1.push_back(d1[8*n +: 8]);
        inf1 = !l1;
      end else inf1 = v1;
      stl1 = v1 && !rdy1;
      hd1 = d1;
      hk1 = k1;
      hl1 = l1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int diff;
    logic [15:0] cs_a;
    #1;
    check("reset_rfs0", 64'(rfs0), 64'd1);
    check("reset_out0", {v0, l0, d0, k0, u0, ps0}, 64'd0);
    check("reset_rfs1", 64'(rfs1), 64'd1);
    check("reset_out1", {v1, l1, d1, k1, u1, ps1}, 64'd0);
    tick; tick;
    ARESET = 1;
    tick;

    // Byte-serial baseline with latency probe
    pl.delete(); pl.push_back(8'h01); pl.push_back(8'hff);
    start0;
    check("lat_rfs_low", 64'(rfs0), 64'd0);
    check("lat_v_n0", 64'(v0), 64'd0);
    tick;
    check("lat_v_n1", 64'(v0), 64'd0);
    tick;
    check("lat_v_n2", 64'(v0), 64'd1);
    wait_idle(0);
    check("base_beats", 64'(cap0.size()), 64'd60);
    check("base_iplen", {cap0[16], cap0[17]}, 64'h001e);
    check("base_udplen", {cap0[38], cap0[39]}, 64'h000a);
    check("base_csum", {cap0[24], cap0[25]}, 64'(exp_cs));
    diff = 0;
    for (int i = 44; i < 60; i++) diff += int'(cap0[i] != 0);
    check("base_pad", 64'(diff), 64'd0);
    check("base_pkts", 64'(ps0), 64'd1);

    // Backpressure: READY low 1..6 cycles ahead of beats 4,5,6,7,20,33
    begin
      int stall_at[6] = '{4, 5, 6, 7, 20, 33};
      int idx, n;
      start0;
      idx = 0;
      n = 0;
      while (!(rfs0 && q0.size() == 0) && n < 2000) begin
        if (idx < 6 && hs0 == stall_at[idx]) begin
          rdy0 = 0;
          repeat (idx + 1) tick;
          rdy0 = 1;
          idx++;
        end else tick;
        n++;
      end
      check("bp_done", 64'(rfs0 && q0.size() == 0), 64'd1);
      check("bp_beats", 64'(cap0.size()), 64'd60);
      check("bp_pkts", 64'(ps0), 64'd2);
    end

    // START during SEND must be ignored
    start0;
    wait_hs0(5);
    st0 = 1;
    tick;
    st0 = 0;
    wait_idle(0);
    repeat (4) begin
      tick;
      check("ign_no_frame", {v0, rfs0}, 64'b01);
    end
    check("ign_pkts", 64'(ps0), 64'd3);

    // Reset mid-frame at beat 10
    start0;
    wait_hs0(10);
    ARESET = 0;
    #1;
    check("abort_valid", {v0, l0, d0, k0}, 64'd0);
    check("abort_rfs", 64'(rfs0), 64'd1);
    check("abort_pkts", 64'(ps0), 64'd0);
    q0.delete();
    id0_m = 0;
    id1_m = 0;
    tick;
    ARESET = 1;
    tick;
    start0;
    wait_idle(0);
    check("abort_next_id", {cap0[18], cap0[19]}, 64'h0000);
    check("abort_next_pkts", 64'(ps0), 64'd1);

    // Randomized frames on the byte-serial instance; inputs scrambled after latch
    rm0 = 1;
    for (int f = 0; f < 8; f++) begin
      rand_fields;
      pl.delete();
      repeat (2) pl.push_back(8'($urandom));
      start0;
      msg0 = 16'($urandom);
      sip = $urandom;
      dmac = {16'($urandom), $urandom};
      wait_idle(0);
    end
    rm0 = 0;
    rdy0 = 1;
    check("rand0_pkts", 64'(ps0), 64'd9);

    // Wide bus, back-to-back frames with identical content
    smac = 48'h54b00bedabba; dmac = 48'h32dabbadebd5;
    sip = 32'h01020304; dip = 32'h0a0b0c0d;
    sport = 16'h66ff; dport = 16'h99dd;
    pl.delete();
    for (int j = 0; j < 20; j++) pl.push_back(8'($urandom));
    cap1.delete();
    start1;
    wait_idle(1);
    start1;
    check("b2b_accepted", 64'(rfs1), 64'd0);
    wait_idle(1);
    check("wide_bytes", 64'(cap1.size()), 64'd124);
    check("wide_beats", 64'(hs1), 64'd16);
    check("wide_iplen", {cap1[16], cap1[17]}, 64'h0030);
    check("wide_udplen", {cap1[38], cap1[39]}, 64'h001c);
    check("b2b_id0", {cap1[18], cap1[19]}, 64'h0000);
    check("b2b_id1", {cap1[80], cap1[81]}, 64'h0001);
    cs_a = {cap1[24], cap1[25]};
    check("b2b_csum", {cap1[86], cap1[87]}, 64'(cs_a - 16'd1));
    check("b2b_csum_model", 64'(cs_a), 64'h20a0);
    check("b2b_pkts", 64'(ps1), 64'd2);

    // Randomized frames on the wide instance
    rm1 = 1;
    for (int f = 0; f < 6; f++) begin
      rand_fields;
      pl.delete();
      repeat (20) pl.push_back(8'($urandom));
      start1;
      msg1 = {5{$urandom}};
      dip = $urandom;
      wait_idle(1);
    end
    rm1 = 0;
    check("rand1_pkts", 64'(ps1), 64'd8);
    check("q0_empty", 64'(q0.size()), 64'd0);
    check("q1_empty", 64'(q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
